// File: rtl/rsa_pkg.sv
// Shared FSM state type and sizing helper for the word-serial RSA loader.
package rsa_pkg;

    localparam int DEFAULT_WORD = 32;

    typedef enum logic [2:0] {
        LD_BASE,
        LD_MOD,
        LD_EXP,
        START,
        WAIT,
        DRAIN
    } state_t;

    function automatic int calc_nw(input int width, input int word);
        return (2 * width) / word;
    endfunction

endpackage

// File: rtl/rsa_word_shifter.sv
// WORD-serial shift register: deserialises words LSW-first into a 2*WIDTH
// register, or parallel-loads a 2*WIDTH value and shifts it out LSW-first.
module rsa_word_shifter
    import rsa_pkg::*;
#(
    parameter int WIDTH = 256,
    parameter int WORD  = DEFAULT_WORD
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_i,
    input  logic [2*WIDTH-1:0] load_data_i,
    input  logic               shift_in_i,
    input  logic [WORD-1:0]    word_i,
    input  logic               shift_out_i,
    output logic [2*WIDTH-1:0] data_o,
    output logic               done_o
);
    localparam int NW = calc_nw(WIDTH, WORD);
    localparam int CW = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [CW-1:0] LAST = CW'(NW - 1);

    logic [2*WIDTH-1:0] data_q, data_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               step;

    assign step   = shift_in_i | shift_out_i;
    assign done_o = step && (cnt_q == LAST);
    assign data_o = data_q;

    always_comb begin
        // NOTE: defaults first so every path assigns data_d/cnt_d and no latch is inferred.
        data_d = data_q;
        cnt_d  = cnt_q;
        if (load_i) begin
            data_d = load_data_i;
            cnt_d  = '0;
        end else if (step) begin
            cnt_d = done_o ? '0 : cnt_q + 1'b1;
            // New words enter at the top, so after NW words word 0 sits at the bottom.
            if (shift_in_i) begin
                data_d = {word_i, data_q[2*WIDTH-1:WORD]};
            end else begin
                data_d = data_q >> WORD;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments; the data register is
        // cleared on reset because the exponent and result outputs must read 0.
        if (!reset) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/rsa_exp_loader.sv
// Word-serial front end for the modular exponentiator: loads base, modulo and
// exponent, runs one exponentiation, then streams the result back out.
module rsa_exp_loader
    import rsa_pkg::*;
#(
    parameter int WIDTH = 256,
    parameter int WORD  = DEFAULT_WORD
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WORD-1:0]    in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WORD-1:0]    out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] exp_base,
    output logic [2*WIDTH-1:0] exp_modulo,
    output logic [2*WIDTH-1:0] exp_exponent,
    output logic               exp_start,
    input  logic               exp_finish,
    input  logic [2*WIDTH-1:0] exp_result,
    output logic               busy,
    output logic               err
);
    state_t             state_q, state_d;
    logic [2*WIDTH-1:0] base_q, base_d, mod_q, mod_d;
    logic               busy_q, busy_d, err_q, err_d, out_valid_q, out_valid_d;
    logic               in_fire, out_fire, op_done, res_done, res_load;
    logic [2*WIDTH-1:0] op_data, op_fill, res_data, res_load_data;
    logic               res_unused;

    assign in_ready  = (state_q == LD_BASE) || (state_q == LD_MOD) || (state_q == LD_EXP);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid_q && out_ready;
    // The exponentiator treats exp_start as its load/reset, so keep it quiet during our reset.
    assign exp_start = reset && (state_q == START);

    // Completed operand including the word being accepted this cycle.
    assign op_fill = {in_data, op_data[2*WIDTH-1:WORD]};

    rsa_word_shifter #(.WIDTH(WIDTH), .WORD(WORD)) u_op_shifter (
        .clk         (clk),
        .reset       (reset),
        .load_i      (1'b0),
        .load_data_i ('0),
        .shift_in_i  (in_fire),
        .word_i      (in_data),
        .shift_out_i (1'b0),
        .data_o      (op_data),
        .done_o      (op_done)
    );

    rsa_word_shifter #(.WIDTH(WIDTH), .WORD(WORD)) u_res_shifter (
        .clk         (clk),
        .reset       (reset),
        .load_i      (res_load),
        .load_data_i (res_load_data),
        .shift_in_i  (1'b0),
        .word_i      ('0),
        .shift_out_i (out_fire),
        .data_o      (res_data),
        .done_o      (res_done)
    );

    assign res_unused = ^res_data[2*WIDTH-1:WORD];

    always_comb begin
        state_d       = state_q;
        base_d        = base_q;
        mod_d         = mod_q;
        busy_d        = busy_q;
        err_d         = err_q;
        res_load      = 1'b0;
        res_load_data = '0;
        case (state_q)
            LD_BASE: begin
                if (in_fire) begin
                    busy_d = 1'b1;
                    if (!busy_q) err_d = 1'b0;
                    if (op_done) begin
                        base_d  = op_fill;
                        state_d = LD_MOD;
                    end
                end
            end
            LD_MOD: begin
                if (op_done) begin
                    mod_d   = op_fill;
                    state_d = LD_EXP;
                end
            end
            LD_EXP: begin
                // The exponent stays in the operand shifter; a zero modulus skips the exponentiator.
                if (op_done) begin
                    if (mod_q == '0) begin
                        err_d    = 1'b1;
                        res_load = 1'b1;
                        state_d  = DRAIN;
                    end else begin
                        state_d = START;
                    end
                end
            end
            START: state_d = WAIT;
            WAIT: begin
                if (exp_finish) begin
                    res_load      = 1'b1;
                    res_load_data = exp_result;
                    state_d       = DRAIN;
                end
            end
            DRAIN: begin
                if (res_done) begin
                    busy_d  = 1'b0;
                    state_d = LD_BASE;
                end
            end
            default: state_d = LD_BASE;
        endcase
    end

    assign out_valid_d = (state_d == DRAIN);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= LD_BASE;
            base_q      <= '0;
            mod_q       <= '0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            mod_q       <= mod_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign exp_base     = base_q;
    assign exp_modulo   = mod_q;
    assign exp_exponent = op_data;
    assign out_data     = res_data[WORD-1:0];
    assign out_valid    = out_valid_q;
    assign busy         = busy_q;
    assign err          = err_q;

endmodule

// File: tb/tb_rsa_exp_loader.sv
// Directed and randomised bench for rsa_exp_loader with a behavioural
// exponentiator stand-in and a result-word scoreboard.
module tb_rsa_exp_loader;
    import rsa_pkg::*;

    localparam int WIDTH = 256;
    localparam int WORD  = 32;
    localparam int W2    = 2 * WIDTH;
    localparam int NW    = W2 / WORD;

    logic            clk = 1'b0;
    logic            reset;
    logic [WORD-1:0] in_data;
    logic            in_valid;
    logic            in_ready;
    logic [WORD-1:0] out_data;
    logic            out_valid;
    logic            out_ready;
    logic [W2-1:0]   exp_base, exp_modulo, exp_exponent, exp_result;
    logic            exp_start;
    logic            exp_finish = 1'b0;
    logic            busy, err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int fin_cyc  = 0;
    int stub_cnt = 0;
    int stub_delay;
    int start_cnt  = 0;
    int long_pulse = 0;
    int drain_viol = 0;
    logic prev_start = 1'b0;
    logic [WORD-1:0] sb[$];

    rsa_exp_loader #(.WIDTH(WIDTH), .WORD(WORD)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .exp_base     (exp_base),
        .exp_modulo   (exp_modulo),
        .exp_exponent (exp_exponent),
        .exp_start    (exp_start),
        .exp_finish   (exp_finish),
        .exp_result   (exp_result),
        .busy         (busy),
        .err          (err)
    );

    always #5 clk = ~clk;

    function automatic logic [W2-1:0] modexp(input logic [W2-1:0] b, input logic [W2-1:0] e,
                                             input logic [W2-1:0] m);
        logic [2*W2-1:0] r, x, mm;
        if (m == '0) return '0;
        mm = {{W2{1'b0}}, m};
        r  = 1;
        r  = r % mm;
        x  = {{W2{1'b0}}, b} % mm;
        for (int i = 0; i < W2; i++) begin
            if (e[i]) r = (r * x) % mm;
            x = (x * x) % mm;
        end
        return r[W2-1:0];
    endfunction

    // Exponentiator stand-in: restarts on every start pulse, finishes after stub_delay cycles.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (exp_start) begin
            exp_finish <= 1'b0;
            exp_result <= modexp(exp_base, exp_exponent, exp_modulo);
            stub_cnt   <= stub_delay;
        end else if (stub_cnt > 0) begin
            stub_cnt <= stub_cnt - 1;
            if (stub_cnt == 1) begin
                exp_finish <= 1'b1;
                fin_cyc    <= cyc + 1;
            end
        end
    end

    always @(negedge clk) begin
        prev_start <= exp_start;
        if (exp_start) start_cnt <= start_cnt + 1;
        if (exp_start && prev_start) long_pulse <= long_pulse + 1;
        if (out_valid && in_ready) drain_viol <= drain_viol + 1;
    end

    task automatic check(input string tag, input logic [W2-1:0] obs, input logic [W2-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_result(input logic [W2-1:0] r);
        for (int k = 0; k < NW; k++) sb.push_back(r[k*WORD +: WORD]);
    endtask

    task automatic send_word(input logic [WORD-1:0] w, input int gap);
        int t = 0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = w;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) check("in_ready_timeout", 1, 0);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic load_job(input logic [W2-1:0] b, input logic [W2-1:0] m, input logic [W2-1:0] e,
                            input int gap_max, input bit chk_err_clear);
        logic [W2-1:0] ops[3];
        ops[0] = b;
        ops[1] = m;
        ops[2] = e;
        for (int o = 0; o < 3; o++) begin
            for (int k = 0; k < NW; k++) begin
                send_word(ops[o][k*WORD +: WORD], (gap_max == 0) ? 0 : int'($urandom_range(gap_max, 0)));
                if (chk_err_clear && o == 0 && k == 0) begin
                    @(negedge clk);
                    check("err_clear_first_word", err, 0);
                end
            end
        end
    endtask

    task automatic drain_job(input int stall_at, input int stall_len, input bit chk_lat, input string tag);
        int got = 0;
        int t = 0;
        int stalled = 0;
        int first_cyc = -1;
        @(negedge clk);
        in_valid = 1'b0;
        while (got < NW && t < 2000) begin
            if (out_valid && first_cyc < 0) first_cyc = cyc;
            out_ready = !(out_valid && got == stall_at && stalled < stall_len);
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check($sformatf("%s_extra_word", tag), 1, 0);
                end else if (!out_ready) begin
                    stalled++;
                    check($sformatf("%s_hold_w%0d", tag, got), out_data, sb[0]);
                end else begin
                    check($sformatf("%s_w%0d", tag, got), out_data, sb.pop_front());
                    got++;
                end
            end
            @(negedge clk);
            t++;
        end
        out_ready = 1'b0;
        check($sformatf("%s_word_count", tag), got, NW);
        check($sformatf("%s_done_valid", tag), out_valid, 0);
        check($sformatf("%s_done_busy", tag), busy, 0);
        if (chk_lat) check($sformatf("%s_latency", tag), first_cyc - fin_cyc, 1);
    endtask

    initial begin
        logic [W2-1:0] rb, rm, re;
        int s0;
        int t;

        reset      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b0;
        stub_delay = 4;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_exp_start", exp_start, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_state", dut.state_q, LD_BASE);
        check("rst_exp_base", exp_base, 0);
        reset = 1'b1;

        s0 = start_cnt;
        push_result(W2'(8));
        load_job(W2'(5), W2'(13), W2'(3), 0, 0);
        drain_job(-1, 0, 1, "small");
        check("small_starts", start_cnt - s0, 1);
        check("small_pulse_len", long_pulse, 0);
        check("small_err", err, 0);
        check("small_base", exp_base, W2'(5));
        check("small_mod", exp_modulo, W2'(13));
        check("small_exp", exp_exponent, W2'(3));

        push_result(W2'(445));
        load_job(W2'(4), W2'(497), W2'(13), 2, 0);
        drain_job(2, 3, 1, "large");

        push_result(W2'(1));
        load_job(W2'(7), W2'(11), W2'(0), 0, 0);
        drain_job(-1, 0, 1, "exp0");

        s0 = start_cnt;
        push_result(W2'(0));
        load_job(W2'(9), W2'(0), W2'(5), 1, 0);
        drain_job(-1, 0, 0, "mod0");
        check("mod0_no_start", start_cnt - s0, 0);
        check("mod0_err", err, 1);

        for (int k = 0; k < NW; k++) begin
            rb[k*WORD +: WORD] = WORD'($urandom);
            rm[k*WORD +: WORD] = WORD'($urandom);
            re[k*WORD +: WORD] = WORD'($urandom);
        end
        rm[0]    = 1'b1;
        rm[W2-1] = 1'b1;
        push_result(modexp(rb, re, rm));
        load_job(rb, rm, re, 3, 1);
        drain_job(5, 20, 1, "rand");
        check("rand_base", exp_base, rb);
        check("rand_mod", exp_modulo, rm);
        check("rand_exp", exp_exponent, re);
        check("rand_err", err, 0);

        stub_delay = 60;
        s0 = start_cnt;
        load_job(W2'(5), W2'(13), W2'(3), 0, 0);
        t = 0;
        while (start_cnt == s0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("abort_start_seen", start_cnt - s0, 1);
        repeat (3) @(negedge clk);
        check("abort_wait_busy", busy, 1);
        check("abort_wait_state", dut.state_q, WAIT);
        reset = 1'b0;
        @(negedge clk);
        check("abort_state", dut.state_q, LD_BASE);
        check("abort_busy", busy, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_exp_start", exp_start, 0);
        reset      = 1'b1;
        stub_delay = 4;

        push_result(W2'(8));
        load_job(W2'(5), W2'(13), W2'(3), 1, 0);
        drain_job(0, 4, 1, "post_rst");

        @(negedge clk);
        check("total_starts", start_cnt, 6);
        check("start_pulse_len", long_pulse, 0);
        check("drain_in_ready_low", drain_viol, 0);
        check("scoreboard_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
